// File: rtl/wide_alu_pipe.sv
// Wide-datapath ALU (ADD/SUB/SHL/SHR/SRA/MUL/POPCNT) with valid/ready on both sides and a
// STAGES-deep result pipeline. Define WIDE_ALU_FLAGS_EN to add pipelined zero/carry outputs.
module wide_alu_pipe #(
  parameter int unsigned W      = 512,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_rs1,
  input  logic [W-1:0]     in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag
`ifdef WIDE_ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam int unsigned SHW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_POP = 3'd6;

  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_diff;
  logic [SHW-1:0] w_sh;
  logic [W-1:0]   w_pop;
  logic [W-1:0]   w_res;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_free;
  logic [W-1:0]      r_res [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];

`ifdef WIDE_ALU_FLAGS_EN
  logic              w_cadd;
  logic              w_carry;
  logic [STAGES-1:0] r_zero;
  logic [STAGES-1:0] r_carry;

  assign {w_cadd, w_sum} = {1'b0, in_rs1} + {1'b0, in_rs2};

  // ADD reports the carry out, SUB the unsigned borrow; everything else clears it.
  always_comb begin
    w_carry = 1'b0;
    if (in_op == OP_ADD) begin
      w_carry = w_cadd;
    end else if (in_op == OP_SUB) begin
      w_carry = (in_rs1 < in_rs2);
    end
  end
`else
  assign w_sum = in_rs1 + in_rs2;
`endif

  assign w_diff = in_rs1 - in_rs2;
  assign w_sh   = in_rs2[SHW-1:0];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(W); i++) begin
      w_pop = w_pop + W'(in_rs1[i]);
    end
  end

  always_comb begin
    w_res = '0;
    case (in_op)
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_diff;
      OP_SHL:  w_res = in_rs1 << w_sh;
      OP_SHR:  w_res = in_rs1 >> w_sh;
      OP_SRA:  w_res = $unsigned($signed(in_rs1) >>> w_sh);
      OP_MUL:  w_res = in_rs1 * in_rs2;
      OP_POP:  w_res = w_pop;
      default: w_res = '0;
    endcase
  end

  // A stage may load when it is empty or its content moves on this cycle (bubbles collapse).
  always_comb begin
    w_free = '0;
    w_free[STAGES-1] = !r_v[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      w_free[k] = !r_v[k] || w_free[k+1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_v <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_res[k] <= '0;
        r_tag[k] <= '0;
      end
    end else begin
      if (w_free[0]) begin
        r_v[0]   <= in_valid;
        r_res[0] <= w_res;
        r_tag[0] <= in_tag;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (w_free[k]) begin
          r_v[k]   <= r_v[k-1];
          r_res[k] <= r_res[k-1];
          r_tag[k] <= r_tag[k-1];
        end
      end
    end
  end

`ifdef WIDE_ALU_FLAGS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_zero  <= '0;
      r_carry <= '0;
    end else begin
      if (w_free[0]) begin
        r_zero[0]  <= (w_res == '0);
        r_carry[0] <= w_carry;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (w_free[k]) begin
          r_zero[k]  <= r_zero[k-1];
          r_carry[k] <= r_carry[k-1];
        end
      end
    end
  end

  assign out_zero  = r_zero[STAGES-1];
  assign out_carry = r_carry[STAGES-1];
`endif

  assign in_ready  = w_free[0];
  assign out_valid = r_v[STAGES-1];
  assign out_res   = r_res[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_wide_alu_pipe.sv
// Self-checking bench for wide_alu_pipe: a W=32/STAGES=2 instance and a W=512/STAGES=4 instance,
// directed vector tables, backpressure, random streaming against a reference model, mid-flight reset.
module tb_wide_alu_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 2;
  localparam int unsigned WB = 512;
  localparam int unsigned SB = 4;
  localparam int unsigned TW = 4;

  typedef struct {
    logic [2:0]   op;
    logic [511:0] a;
    logic [511:0] b;
    logic [3:0]   tag;
    logic [511:0] res;
    logic         cy;
  } vec_t;

  logic clk;
  logic arst_n;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_rs1, in_rs2, out_res;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_zero, out_carry;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]    b_in_op;
  logic [WB-1:0] b_in_rs1, b_in_rs2, b_out_res;
  logic [TW-1:0] b_in_tag, b_out_tag;
  logic          b_out_zero, b_out_carry;

  int n_chk = 0;
  int n_err = 0;

  vec_t t32 [15];
  vec_t t512 [6];

  wide_alu_pipe #(.W(W), .STAGES(S), .TAG_W(TW)) u_dut32 (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
`ifdef WIDE_ALU_FLAGS_EN
    , .out_zero(out_zero), .out_carry(out_carry)
`endif
  );

  wide_alu_pipe #(.W(WB), .STAGES(SB), .TAG_W(TW)) u_dut512 (
    .clk(clk), .arst_n(arst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_res(b_out_res), .out_tag(b_out_tag)
`ifdef WIDE_ALU_FLAGS_EN
    , .out_zero(b_out_zero), .out_carry(b_out_carry)
`endif
  );

`ifndef WIDE_ALU_FLAGS_EN
  assign out_zero    = 1'b0;
  assign out_carry   = 1'b0;
  assign b_out_zero  = 1'b0;
  assign b_out_carry = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [511:0] a, input logic [511:0] b,
                              input logic [3:0] tag, input logic [511:0] res, input logic cy);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.cy = cy;
    return v;
  endfunction

  // Independent 32-bit reference for the streaming tests.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r  = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a + ~b + 32'd1;
      3'd2: r = a << sh;
      3'd3: r = a >> sh;
      3'd4: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hffff_ffff >> sh);
      end
      3'd5: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
      end
      3'd6: for (int i = 0; i < 32; i++) if (a[i]) r = r + 32'd1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One isolated op: exact latency, result, tag and flags, then drained.
  task automatic apply_vec(input bit big, input vec_t v, input string nm);
    int lat;
    lat = big ? int'(SB) : int'(S);
    @(negedge clk);
    out_ready = 1'b1; b_out_ready = 1'b1;
    if (big) begin
      b_in_valid = 1'b1; b_in_op = v.op; b_in_rs1 = v.a; b_in_rs2 = v.b; b_in_tag = v.tag;
    end else begin
      in_valid = 1'b1; in_op = v.op; in_rs1 = v.a[31:0]; in_rs2 = v.b[31:0]; in_tag = v.tag;
    end
    #1;
    chk({nm, "_in_ready"}, big ? b_in_ready : in_ready, 1'b1);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      in_valid = 1'b0; b_in_valid = 1'b0;
      #1;
      chk({nm, "_early_valid"}, big ? b_out_valid : out_valid, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk({nm, "_valid"}, big ? b_out_valid : out_valid, 1'b1);
    chk({nm, "_res"}, big ? b_out_res : 512'(out_res), v.res);
    chk({nm, "_tag"}, big ? b_out_tag : out_tag, v.tag);
`ifdef WIDE_ALU_FLAGS_EN
    chk({nm, "_zero"}, big ? b_out_zero : out_zero, (v.res == '0));
    chk({nm, "_carry"}, big ? b_out_carry : out_carry, v.cy);
`endif
  endtask

  // Streams n_ops through the 32-bit instance with a scoreboard queue.
  task automatic run_stream(input int n_ops, input int in_pct, input int rdy_pct,
                            input int rdy_start, input bit directed, input int max_cyc);
    logic [31:0] exp_res [$];
    logic [3:0]  exp_tag [$];
    logic [31:0] pres;
    logic [3:0]  ptag;
    bit          stalled, pending;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 0; pending = 0; pres = '0; ptag = '0;
    while (got < n_ops && cyc < max_cyc) begin
      @(negedge clk);
      if (!pending && sent < n_ops && int'($urandom_range(99)) < in_pct) begin
        pending = 1;
        if (directed) begin
          in_op = 3'd0; in_rs1 = 32'(sent); in_rs2 = 32'd100; in_tag = 4'(sent);
        end else begin
          in_op  = 3'($urandom_range(7));
          in_rs1 = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
          in_rs2 = ($urandom_range(3) == 0) ? 32'hffff_ffff : $urandom;
          in_tag = 4'($urandom_range(15));
        end
      end
      in_valid  = pending;
      out_ready = (cyc >= rdy_start) && (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_res", out_res, pres);
        chk("stall_tag", out_tag, ptag);
      end
      if (out_valid && out_ready) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          chk("stream_res", out_res, exp_res.pop_front());
          chk("stream_tag", out_tag, exp_tag.pop_front());
        end
        got++;
      end
      if (in_pct == 100 && rdy_pct == 100 && cyc >= rdy_start && in_valid)
        chk("full_rate_in_ready", in_ready, 1'b1);
      if (in_valid && in_ready) begin
        exp_res.push_back(ref_alu(in_op, in_rs1, in_rs2));
        exp_tag.push_back(in_tag);
        sent++;
        pending = 0;
      end
      if (rdy_start > 0 && cyc == rdy_start - 1) begin
        chk("bp_accepts", 32'(sent), 32'(S));
        chk("bp_in_ready", in_ready, 1'b0);
      end
      stalled = out_valid && !out_ready;
      pres = out_res; ptag = out_tag;
      cyc++;
    end
    chk("stream_complete", 32'(got), 32'(n_ops));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("stream_leftover", 32'(exp_res.size()), 32'd0);
    chk("stream_no_dup", out_valid, 1'b0);
  endtask

  initial begin
    t32[0]  = mk(3'd0, 512'hffff_ffff, 512'h1,         4'd3,  512'h0,         1'b1);
    t32[1]  = mk(3'd1, 512'h5,         512'h7,         4'd1,  512'hffff_fffe, 1'b1);
    t32[2]  = mk(3'd4, 512'h8000_0000, 512'h24,        4'd2,  512'hf800_0000, 1'b0);
    t32[3]  = mk(3'd2, 512'h1,         512'hffff_ffe0, 4'd4,  512'h1,         1'b0);
    t32[4]  = mk(3'd5, 512'h1_0000,    512'h1_0000,    4'd5,  512'h0,         1'b0);
    t32[5]  = mk(3'd6, 512'hf0f0_0001, 512'h0,         4'd6,  512'h9,         1'b0);
    t32[6]  = mk(3'd6, 512'hffff_ffff, 512'h0,         4'd7,  512'h20,        1'b0);
    t32[7]  = mk(3'd3, 512'h8000_0000, 512'h1f,        4'd8,  512'h1,         1'b0);
    t32[8]  = mk(3'd2, 512'h1,         512'h1f,        4'd9,  512'h8000_0000, 1'b0);
    t32[9]  = mk(3'd0, 512'h1,         512'h2,         4'd10, 512'h3,         1'b0);
    t32[10] = mk(3'd1, 512'h7,         512'h5,         4'd11, 512'h2,         1'b0);
    t32[11] = mk(3'd7, 512'hdead_beef, 512'h1234,      4'd12, 512'h0,         1'b0);
    t32[12] = mk(3'd4, 512'h7fff_ffff, 512'h1f,        4'd13, 512'h0,         1'b0);
    t32[13] = mk(3'd4, 512'h8000_0000, 512'h1f,        4'd14, 512'hffff_ffff, 1'b0);
    t32[14] = mk(3'd5, 512'h1234_5678, 512'h9,         4'd15, 512'ha3d7_0a38, 1'b0);

    t512[0] = mk(3'd0, {512{1'b1}},        512'h1,         4'd1, 512'h0,             1'b1);
    t512[1] = mk(3'd1, 512'h0,             512'h1,         4'd2, {512{1'b1}},        1'b1);
    t512[2] = mk(3'd5, 512'h1 << 256,      512'h1 << 256,  4'd3, 512'h0,             1'b0);
    t512[3] = mk(3'd5, 512'h3,             512'h5,         4'd4, 512'hf,             1'b0);
    t512[4] = mk(3'd6, {512{1'b1}},        512'h0,         4'd5, 512'd512,           1'b0);
    t512[5] = mk(3'd4, 512'h1 << 511,      512'h201,       4'd6, 512'h3 << 510,      1'b0);

    arst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_op = '0; b_in_rs1 = '0; b_in_rs2 = '0; b_in_tag = '0;
    b_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_res", out_res, 32'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply_vec(1'b0, t32[i], $sformatf("v32_%0d", i));
    for (int i = 0; i < 6; i++)  apply_vec(1'b1, t512[i], $sformatf("v512_%0d", i));

    run_stream(6, 100, 100, 5, 1'b1, 100);
    run_stream(1000, 80, 50, 0, 1'b0, 20000);
    run_stream(40, 100, 100, 0, 1'b0, 200);

    // Two ops in flight on each instance, then a one-cycle reset.
    @(negedge clk);
    out_ready = 1'b0; b_out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'd1; in_rs2 = 32'd1; in_tag = 4'd9;
    b_in_valid = 1'b1; b_in_op = 3'd0; b_in_rs1 = 512'd1; b_in_rs2 = 512'd1; b_in_tag = 4'd9;
    @(negedge clk);
    in_tag = 4'd10; b_in_tag = 4'd10;
    @(negedge clk);
    in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_res", out_res, 32'h0);
    chk("midrst_out_tag", out_tag, 4'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_b_out_valid", b_out_valid, 1'b0);
    chk("midrst_b_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    arst_n = 1'b1;
    out_ready = 1'b1; b_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("ghost_valid", out_valid, 1'b0);
      chk("ghost_b_valid", b_out_valid, 1'b0);
    end
    apply_vec(1'b0, t32[1], "post_rst_32");
    apply_vec(1'b1, t512[3], "post_rst_512");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
